ps2_cursor_painter: RTL
=======================

PS2_CURSOR_PAINTER -- requirements
Module: ps2_cursor_painter

Interface
REQ-001 SHALL have parameter BOX_SIZE, default 16: cursor square edge in pixels (range 1..64).
REQ-002 SHALL have parameter STEP, default 4: pixels moved per frame per held arrow key.
REQ-003 SHALL have parameter FG_COLOR, default 12'h00F: cursor colour ([3:0] red, [7:4] green, [11:8] blue).
REQ-004 SHALL have parameter BG_COLOR, default 12'h000: background colour.
REQ-005 SHALL have port clk  in  1  pixel-domain clock.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port scan_code  in  8  PS/2 scan-code byte, set 2.
REQ-008 SHALL have port scan_valid  in  1  one-cycle strobe qualifying scan_code.
REQ-009 SHALL have port x_coord  in  10  current pixel column from the VGA timing stage.
REQ-010 SHALL have port y_coord  in  10  current pixel row from the VGA timing stage.
REQ-011 SHALL have port frame_tick  in  1  one-cycle pulse, once per frame, during vertical blanking.
REQ-012 SHALL have port pixel_color  out  12  colour for (x_coord, y_coord), registered.
REQ-013 SHALL have ports cursor_x  out  10  and cursor_y  out  10  holding the cursor top-left position.

Function
REQ-014 SHALL decode scan bytes with an FSM in states IDLE, EXT, BRK, EXT_BRK, advancing only on cycles where scan_valid=1.
REQ-015 IDLE: E0->EXT; F0->BRK; any other byte->IDLE.
REQ-016 EXT: F0->EXT_BRK; 75/72/6B/74 set held bit up/down/left/right and go to IDLE; any other byte->IDLE.
REQ-017 EXT_BRK: 75/72/6B/74 clear the matching held bit and go to IDLE; any other byte->IDLE.
REQ-018 BRK: any byte->IDLE with no held-bit change (non-extended breaks ignored).
REQ-019 Repeated make codes for an already-held key SHALL leave it held.
REQ-020 On frame_tick, cursor SHALL move STEP per held direction: left/right on x, up/down on y.
REQ-021 Opposing directions held together (up+down, left+right) SHALL produce no motion on that axis.
REQ-022 Without wrap: x SHALL clamp to 0..640-BOX_SIZE and y to 0..480-BOX_SIZE, with no underflow through 10-bit arithmetic.
REQ-023 When frame_tick and scan_valid coincide, motion SHALL use the held bits from before that byte.
REQ-024 Inside-box test: cursor_x <= x_coord < cursor_x+BOX_SIZE and cursor_y <= y_coord < cursor_y+BOX_SIZE.
REQ-025 pixel_color SHALL equal FG_COLOR inside the box, 12'h000 when x_coord>=640 or y_coord>=480, and BG_COLOR otherwise.
REQ-026 Latency SHALL be exactly 1 clk from x_coord/y_coord to pixel_color.

Reset
REQ-027 While rstn=0: FSM=IDLE, held bits=0, cursor_x=(640-BOX_SIZE)/2 (312), cursor_y=(480-BOX_SIZE)/2 (232), pixel_color=0.
REQ-028 Reset mid-sequence (e.g. after E0) SHALL discard the partial sequence; the first byte after release is decoded from IDLE.

Configuration
REQ-029 With CURSOR_WRAP_EN defined, motion past the right/bottom limit SHALL wrap to 0, and motion below 0 SHALL wrap to 640-BOX_SIZE / 480-BOX_SIZE.
REQ-030 Without CURSOR_WRAP_EN, clamping per REQ-022 SHALL apply.

Structure
REQ-031 A shared package SHALL hold the screen constants (640, 480), scan-code constants (E0, F0, 75, 72, 6B, 74) and the FSM state typedef.
REQ-032 Decoding SHALL live in a sub-module ps2_arrow_decoder that outputs the 4 held bits; movement and rendering stay in the top module.

Verification
REQ-033 Reset release -> cursor (312,232); pixel (312,232) gives 12'h00F one clk later; (311,232) gives 12'h000.
REQ-034 Send E0 74, then 3 frame_ticks -> cursor_x=324; send E0 F0 74, then 1 frame_tick -> cursor_x stays 324.
REQ-035 Hold left from cursor_x=2 with 1 frame_tick -> 0 without wrap, 624 with CURSOR_WRAP_EN.
REQ-036 Hold up+down, 5 frame_ticks -> cursor_y unchanged at 232.
REQ-037 Send F0 74 (non-extended break) while right is held -> right stays held; send E0 then 1C -> no held change, FSM back to IDLE.
REQ-038 Send E0, pulse rstn, then send 74 -> no held bit set.

Source files
------------

// File: rtl/ps2_cursor_painter_pkg.sv
// Shared constants and types for the PS/2-driven cursor painter.
// Screen geometry, set-2 scan codes, decoder state encoding and held-bit layout.
package ps2_cursor_painter_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int HELD_UP    = 0;
  localparam int HELD_DOWN  = 1;
  localparam int HELD_LEFT  = 2;
  localparam int HELD_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

  // One-hot held-bit mask for an arrow scan code, zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[HELD_UP]    = 1'b1;
      SC_DOWN:  m[HELD_DOWN]  = 1'b1;
      SC_LEFT:  m[HELD_LEFT]  = 1'b1;
      SC_RIGHT: m[HELD_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_cursor_painter_arrow_decoder.sv
// Turns a stream of PS/2 set-2 bytes into four "arrow key held" bits.
// Only extended (E0-prefixed) arrow make/break sequences change the held state.
module ps2_arrow_decoder
  import ps2_cursor_painter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] scan_code_i,
  input  logic       scan_valid_i,
  output logic [3:0] held_o
);

  dec_state_e state_q, state_d;
  logic [3:0] held_q, held_d;
  logic [3:0] mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      held_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    mask    = arrow_mask(scan_code_i);
    if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code_i == SC_EXT)      state_d = ST_EXT;
          else if (scan_code_i == SC_BRK) state_d = ST_BRK;
          else                            state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (scan_code_i == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            held_d  = held_q | mask;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          held_d  = held_q & ~mask;
          state_d = ST_IDLE;
        end
        // Non-extended breaks carry no arrow information; swallow the byte.
        ST_BRK:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign held_o = held_q;

endmodule

// File: rtl/ps2_cursor_painter.sv
// Keyboard-steered square cursor overlaid on a 640x480 VGA raster.
// Define CURSOR_WRAP_EN to wrap the cursor at screen edges instead of clamping.
module ps2_cursor_painter
  import ps2_cursor_painter_pkg::*;
#(
  parameter int unsigned BOX_SIZE = 16,
  parameter int unsigned STEP     = 4,
  parameter logic [11:0] FG_COLOR = 12'h00F,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  input  logic [9:0]  x_coord,
  input  logic [9:0]  y_coord,
  input  logic        frame_tick,
  output logic [11:0] pixel_color,
  output logic [9:0]  cursor_x,
  output logic [9:0]  cursor_y
);

  localparam logic [9:0] MAX_X   = 10'(SCREEN_W - BOX_SIZE);
  localparam logic [9:0] MAX_Y   = 10'(SCREEN_H - BOX_SIZE);
  localparam logic [9:0] HOME_X  = 10'((SCREEN_W - BOX_SIZE) / 2);
  localparam logic [9:0] HOME_Y  = 10'((SCREEN_H - BOX_SIZE) / 2);
  localparam logic [9:0] STEP10  = 10'(STEP);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  logic [3:0]  held;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
  logic [11:0] color_q, color_d;
  logic        inside_x, inside_y, on_screen;

  ps2_arrow_decoder u_decoder (
    .clk          (clk),
    .rstn         (rstn),
    .scan_code_i  (scan_code),
    .scan_valid_i (scan_valid),
    .held_o       (held)
  );

  // Move one axis by STEP; 11-bit sum and explicit compare keep 10-bit math from wrapping silently.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [9:0] max_pos);
    logic [10:0] up_sum;
    logic [9:0]  nxt;
    up_sum = {1'b0, pos} + {1'b0, STEP10};
    nxt    = pos;
    if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
      if (up_sum > {1'b0, max_pos}) nxt = 10'd0;
`else
      if (up_sum > {1'b0, max_pos}) nxt = max_pos;
`endif
      else nxt = up_sum[9:0];
    end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
      if (pos < STEP10) nxt = max_pos;
`else
      if (pos < STEP10) nxt = 10'd0;
`endif
      else nxt = pos - STEP10;
    end
    return nxt;
  endfunction

  // Held bits are registered, so a byte arriving with frame_tick only affects the next frame.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (frame_tick) begin
      cx_d = step_axis(cx_q, held[HELD_RIGHT], held[HELD_LEFT], MAX_X);
      cy_d = step_axis(cy_q, held[HELD_DOWN],  held[HELD_UP],   MAX_Y);
    end
  end

  always_comb begin
    inside_x  = ({1'b0, x_coord} >= {1'b0, cx_q}) && ({1'b0, x_coord} < ({1'b0, cx_q} + BOX11));
    inside_y  = ({1'b0, y_coord} >= {1'b0, cy_q}) && ({1'b0, y_coord} < ({1'b0, cy_q} + BOX11));
    on_screen = (x_coord < 10'(SCREEN_W)) && (y_coord < 10'(SCREEN_H));
    color_d   = BG_COLOR;
    if (!on_screen)               color_d = 12'h000;
    else if (inside_x && inside_y) color_d = FG_COLOR;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx_q    <= HOME_X;
      cy_q    <= HOME_Y;
      color_q <= 12'h000;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
    end
  end

  assign pixel_color = color_q;
  assign cursor_x    = cx_q;
  assign cursor_y    = cy_q;

endmodule
